mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//   Iterative RV32M multiply/divide sequencer (MUL, MULHU, DIVU, REMU) built around one alu instance.
//   Runs shift-add multiply / restoring divide, one bit per clock, 32 iterations.
//   Sits beside the main ALU in the execute stage. Request/response valid-ready handshake toward the core.
//   One operation in flight; no overlap between the response and the next request.
// PARAMETERS
//   DIV0_FAST  1  1: divide-by-zero skips iteration, result in 1 cycle; 0: runs full 32 iterations
// PORTS
//   clk_i        in   1   clock, rising edge
//   rst_ni       in   1   reset, asynchronous, active-low
//   req_valid_i  in   1   request valid
//   req_ready_o  out  1   request ready, =(state==IDLE)
//   op_i         in   2   mdu_op_e operation, sampled on request handshake
//   a_i          in   32  operand A (multiplicand / dividend)
//   b_i          in   32  operand B (multiplier / divisor)
//   rsp_valid_o  out  1   result valid
//   rsp_ready_i  in   1   result accepted
//   result_o     out  32  registered result, stable while rsp_valid_o=1
//   busy_o       out  1   state!=IDLE
// BEHAVIOUR
//   Reset (rst_ni=0, async): state=IDLE, cnt=0, all datapath regs=0, result_o=0, rsp_valid_o=0, busy_o=0.
//     req_ready_o=1 during reset; inputs are ignored while rst_ni=0.
//   FSM states: IDLE, MUL, DIV, DONE.
//   IDLE: a handshake (req_valid_i & req_ready_o) latches op, a, b and sets cnt=0.
//     MUL/MULHU: next=MUL; hi=0, lo=a.
//     DIVU/REMU: r=0, q=a; next=DIV.
//     If b==0 and DIV0_FAST=1, next=DONE with result=(DIVU ? 32'hFFFF_FFFF : a).
//   MUL iteration:
//     alu runs ALU_ADD(hi,b).
//     Carry c = (hi[31]&b[31]) | ((hi[31]|b[31]) & ~sum[31]).
//     If lo[0]: {hi,lo}={c,sum,lo[31:1]}; else {hi,lo}={1'b0,hi,lo[31:1]}.
//   DIV iteration:
//     {m,r'}={r,q[31]}, q'=q<<1.
//     alu runs ALU_SUB(r',b).
//     Borrow bw = (~r'[31]&b[31]) | ((~r'[31]|b[31]) & diff[31]).
//     If m | ~bw: r=diff, q=q'|1; else r=r', q=q'.
//   Both: cnt++. The step where cnt==31 writes result_o and moves to DONE.
//     MUL: result_o=lo. MULHU: result_o=hi. DIVU: result_o=q. REMU: result_o=r. All values post-update.
//   Latency: handshake in cycle 0, rsp_valid_o=1 from cycle 33 (cycle 1 for fast div-by-zero).
//   Div-by-zero with DIV0_FAST=0 produces the same values naturally (q=all ones, r=a).
//   DONE: rsp_valid_o=1, result_o held. On rsp_ready_i=1, next=IDLE and rsp_valid_o=0 next cycle.
//     req_ready_o=0 in DONE; earliest next accept is the cycle after the response handshake.
//   Operand inputs and op_i are ignored whenever state!=IDLE.
//   Reset mid-operation abandons the op: no response, FSM returns to IDLE.
//   Arithmetic is all unsigned and mod 2^32. No overflow flag exists.
//   The alu alu_op_i is ALU_ADD in IDLE/MUL/DONE and ALU_SUB in DIV; the alu flag_o is unused.
// STRUCTURE
//   mdu_opcodes_pkg holds typedef enum logic [1:0] mdu_op_e {MDU_MUL=0, MDU_MULHU=1, MDU_DIVU=2, MDU_REMU=3}.
//   The FSM state typedef stays local to the module. ALU codes come from alu_opcodes_pkg.
//   Sub-module: exactly one alu instance (i_alu), used as the shared add/sub datapath.
//   Counter is 5 bits. hi/lo and r/q share the same two 32-bit registers.
// TESTING
//   MUL 7*6 -> result_o=42, rsp_valid_o rises exactly 33 cycles after the handshake.
//   MUL / MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0x0000_0001 / 0xFFFF_FFFE.
//   DIVU / REMU 100,7 -> 14 / 2.
//   DIVU 0x8000_0000,3 -> 0x2AAA_AAAA.
//   DIVU / REMU 0x1234,0:
//     DIV0_FAST=1 -> 0xFFFF_FFFF / 0x1234 with rsp_valid_o at cycle 1.
//     DIV0_FAST=0 -> same values at cycle 33.
//   Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and result_o held, req_ready_o=0.
//     req_valid_i pulsed with new operands during this window is ignored; the next op is accepted only after the response handshake.
//   Reset mid-op: rst_ni=0 at iteration 10 of MUL 5*5 -> rsp_valid_o=0 and busy_o=0 immediately.
//     After release, DIVU 9,2 -> 4.
//   Random: 1000 random op/a/b with random rsp_ready_i stalls vs reference model -> zero mismatches.

Source files
------------

// File: rtl/alu_opcodes_pkg.sv
// rtl/alu_opcodes_pkg.sv - operation codes for the shared execute-stage alu
package alu_opcodes_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

endpackage

// File: rtl/mdu_opcodes_pkg.sv
// rtl/mdu_opcodes_pkg.sv - RV32M subset opcodes handled by the iterative mdu
package mdu_opcodes_pkg;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'd0,
    MDU_MULHU = 2'd1,
    MDU_DIVU  = 2'd2,
    MDU_REMU  = 2'd3
  } mdu_op_e;

  localparam int unsigned MDU_XLEN = 32;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational alu; flag_o reports a zero result
module alu
  import alu_opcodes_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     alu_op_i,
  output logic [31:0] result_o,
  output logic        flag_o
);

  always_comb begin
    result_o = '0;
    unique case (alu_op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      default: result_o = '0;
    endcase
  end

  assign flag_o = (result_o == 32'd0);

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - bit-serial MUL/MULHU/DIVU/REMU sequencer around one shared alu
module mdu_seq
  import mdu_opcodes_pkg::*;
  import alu_opcodes_pkg::*;
#(
  parameter int unsigned DIV0_FAST = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  mdu_op_e     op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  // hi_q doubles as the remainder, lo_q as the quotient during division
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;

  logic [31:0] alu_a;
  logic [31:0] alu_res;
  alu_op_e     alu_op;
  logic        alu_flag_unused;
  logic [31:0] r_shift;
  logic        carry;
  logic        borrow;
  logic        div_by_zero;

  assign r_shift = {hi_q[30:0], lo_q[31]};
  assign alu_a   = (state_q == S_DIV) ? r_shift : hi_q;
  assign alu_op  = (state_q == S_DIV) ? ALU_SUB : ALU_ADD;

  alu i_alu (
    .a_i      (alu_a),
    .b_i      (b_q),
    .alu_op_i (alu_op),
    .result_o (alu_res),
    .flag_o   (alu_flag_unused)
  );

  // Carry/borrow recovered from operand and result MSBs so the alu stays 32 bits wide
  assign carry  = (hi_q[31] & b_q[31]) | ((hi_q[31] | b_q[31]) & ~alu_res[31]);
  assign borrow = (~r_shift[31] & b_q[31]) | ((~r_shift[31] | b_q[31]) & alu_res[31]);

  assign div_by_zero = (DIV0_FAST != 0) && (b_i == 32'd0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d  = op_i;
          b_d   = b_i;
          cnt_d = 5'd0;
          hi_d  = 32'd0;
          lo_d  = a_i;
          if (op_i == MDU_MUL || op_i == MDU_MULHU) begin
            state_d = S_MUL;
          end else if (div_by_zero) begin
            state_d  = S_DONE;
            result_d = (op_i == MDU_DIVU) ? 32'hFFFF_FFFF : a_i;
          end else begin
            state_d = S_DIV;
          end
        end
      end

      S_MUL: begin
        if (lo_q[0]) begin
          {hi_d, lo_d} = {carry, alu_res, lo_q[31:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          result_d = (op_q == MDU_MUL) ? lo_d : hi_d;
        end
      end

      S_DIV: begin
        // A set bit shifted out of r means r' already exceeds any 32-bit divisor
        if (hi_q[31] | ~borrow) begin
          hi_d = alu_res;
          lo_d = {lo_q[30:0], 1'b1};
        end else begin
          hi_d = r_shift;
          lo_d = {lo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          result_d = (op_q == MDU_DIVU) ? lo_d : hi_d;
        end
      end

      S_DONE: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= MDU_MUL;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - randomized self-checking bench for mdu_seq against a behavioural model
module tb_mdu_seq;
  import mdu_opcodes_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
  mdu_op_e     op;
  logic [31:0] a, b, result;
  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready, s_busy;
  mdu_op_e     s_op;
  logic [31:0] s_a, s_b, s_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_seq #(.DIV0_FAST(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .a_i(a), .b_i(b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .result_o(result), .busy_o(busy)
  );

  mdu_seq #(.DIV0_FAST(0)) dut_slow (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(s_req_valid), .req_ready_o(s_req_ready),
    .op_i(s_op), .a_i(s_a), .b_i(s_b),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(s_rsp_ready),
    .result_o(s_result), .busy_o(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input mdu_op_e o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      MDU_MUL:   return p[31:0];
      MDU_MULHU: return p[63:32];
      MDU_DIVU:  return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      default:   return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_latency(input mdu_op_e o, input logic [31:0] y);
    if ((o == MDU_DIVU || o == MDU_REMU) && y == 32'd0) return 1;
    return 33;
  endfunction

  // Issue on the fast instance, then wait for the response; scrambles operands while busy
  task automatic run_op(input mdu_op_e o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat);
    int waited = 0;
    while (!req_ready && waited < 100) begin tick; waited++; end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    op = o; a = x; b = y; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      op = mdu_op_e'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      tick;
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    res = result;
  endtask

  task automatic accept;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_slow(input mdu_op_e o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
    s_op = o; s_a = x; s_b = y; s_req_valid = 1'b1;
    tick;
    s_req_valid = 1'b0;
    lat = 1;
    while (!s_rsp_valid && lat < 100) begin tick; lat++; end
    res = s_result;
    s_rsp_ready = 1'b1;
    tick;
    s_rsp_ready = 1'b0;
  endtask

  typedef struct {
    mdu_op_e     o;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  initial begin
    logic [31:0] res, held;
    int          lat;
    vec_t        dir[$];

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    op = MDU_MUL; a = '0; b = '0;
    s_req_valid = 1'b0; s_rsp_ready = 1'b0; s_op = MDU_MUL; s_a = '0; s_b = '0;
    tick; tick;
    check("reset_result", result, 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    tick;

    run_op(MDU_MUL, 32'd7, 32'd6, res, lat);
    check("mul_7x6", res, 32'd42);
    check("mul_latency", 32'(lat), 32'd33);
    check("done_busy", 32'(busy), 32'd1);
    accept;

    dir.push_back('{MDU_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF});
    dir.push_back('{MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    dir.push_back('{MDU_DIVU,  32'd100,       32'd7});
    dir.push_back('{MDU_REMU,  32'd100,       32'd7});
    dir.push_back('{MDU_DIVU,  32'h8000_0000, 32'd3});
    dir.push_back('{MDU_DIVU,  32'h1234,      32'd0});
    dir.push_back('{MDU_REMU,  32'h1234,      32'd0});
    foreach (dir[i]) begin
      run_op(dir[i].o, dir[i].x, dir[i].y, res, lat);
      check($sformatf("dir%0d_result", i), res, ref_model(dir[i].o, dir[i].x, dir[i].y));
      check($sformatf("dir%0d_latency", i), 32'(lat), 32'(ref_latency(dir[i].o, dir[i].y)));
      accept;
    end
    // Independent constants for the named corner cases
    run_op(MDU_DIVU, 32'h8000_0000, 32'd3, res, lat);
    check("divu_8000_3", res, 32'h2AAA_AAAA);
    accept;

    run_slow(MDU_DIVU, 32'h1234, 32'd0, res, lat);
    check("slow_div0_q", res, 32'hFFFF_FFFF);
    check("slow_div0_lat", 32'(lat), 32'd33);
    run_slow(MDU_REMU, 32'h1234, 32'd0, res, lat);
    check("slow_div0_r", res, 32'h1234);
    check("slow_div0_r_lat", 32'(lat), 32'd33);

    // Backpressure with an intruding request that must be ignored
    run_op(MDU_MUL, 32'd123, 32'd456, res, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin req_valid = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd10; end
      else req_valid = 1'b0;
      tick;
      check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_result%0d", i), result, 32'd56088);
      check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    accept;
    check("bp_idle_busy", 32'(busy), 32'd0);
    run_op(MDU_DIVU, 32'd1000, 32'd10, res, lat);
    check("bp_next_op", res, 32'd100);
    accept;

    // Reset in the middle of a multiply
    run_op(MDU_MUL, 32'd5, 32'd5, res, lat);
    accept;
    op = MDU_MUL; a = 32'd5; b = 32'd5; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (10) tick;
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    run_op(MDU_DIVU, 32'd9, 32'd2, res, lat);
    check("after_reset_div", res, 32'd4);
    accept;

    for (int n = 0; n < 1000; n++) begin
      mdu_op_e     ro;
      logic [31:0] rx, ry;
      int          stall;
      ro = mdu_op_e'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1:       ry = $urandom_range(1, 15);
        2:       ry = rx;
        default: ry = $urandom;
      endcase
      run_op(ro, rx, ry, res, lat);
      check($sformatf("rnd%0d_result", n), res, ref_model(ro, rx, ry));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(ref_latency(ro, ry)));
      stall = $urandom_range(0, 3);
      held = ref_model(ro, rx, ry);
      repeat (stall) tick;
      check($sformatf("rnd%0d_held", n), result, held);
      accept;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
